alb_pipe: RTL

Parametrised, pipelined successor to the 4-bit arithmetic-logic block. It has WIDTH-bit operands, a 3-bit opcode with 8 micro-operations, and valid/ready handshakes on input and output. It holds a flag register so that carry can chain across beats in multi-word add/subtract. It sits between the operand-fetch stage and the result/writeback stage of the datapath.

---
 rtl/alb_pipe_if.sv | 29 ++
 rtl/alb_pipe.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alb_pipe_if.sv
// Operand/result handshake bundle for the alb_pipe arithmetic-logic block.
// The slave modport is the block itself; master is the upstream/downstream side.
interface alb_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] s_in;
    logic             ci;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f_out;
    logic             co;
    logic             vo;
    logic             no;
    logic             zo;

    modport slave (
        input  in_valid, r_in, s_in, ci, op, out_ready,
        output in_ready, out_valid, f_out, co, vo, no, zo
    );

    modport master (
        output in_valid, r_in, s_in, ci, op, out_ready,
        input  in_ready, out_valid, f_out, co, vo, no, zo
    );
endinterface

// File: rtl/alb_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes and a chained carry flag.
// Optional build macro ALB_SAT_EN: ADD/SUB saturate on signed overflow.
module alb_pipe #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    alb_pipe_if.slave  bus
);
    localparam logic [2:0] OP_OR   = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ANDN = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_ADC  = 3'b110;
    localparam logic [2:0] OP_SBC  = 3'b111;

    // Stage 1: captured operands
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             ci_q, ci_d;
    logic [2:0]       op_q, op_d;

    // Stage 2: registered result and flags
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             co_q, co_d;
    logic             vo_q, vo_d;
    logic             no_q, no_d;
    logic             zo_q, zo_d;

    logic             adv;
    logic             in_ready;
    logic             accept;
    logic             move;

    logic [WIDTH-1:0] alu_b;
    logic             alu_cin;
    logic [WIDTH:0]   alu_sum;
    logic [WIDTH-1:0] alu_f;
    logic             alu_c;
    logic             alu_v;

    assign adv      = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || adv;
    assign accept   = bus.in_valid && in_ready;
    assign move     = s1_valid_q && adv;

    // SUB/SBC share the low opcode bits 11 (invert S); ADC/SBC take carry from S2.
    always_comb begin
        alu_b   = (op_q[1:0] == 2'b11) ? ~s_q : s_q;
        alu_cin = op_q[2] ? co_q : ci_q;
        alu_sum = {1'b0, r_q} + {1'b0, alu_b} + {{WIDTH{1'b0}}, alu_cin};
        alu_f   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_OR:   alu_f = r_q | s_q;
            OP_ANDN: alu_f = ~r_q & s_q;
            OP_AND:  alu_f = r_q & s_q;
            OP_XOR:  alu_f = r_q ^ s_q;
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                alu_f = alu_sum[WIDTH-1:0];
                alu_c = alu_sum[WIDTH];
                alu_v = (r_q[WIDTH-1] == alu_b[WIDTH-1]) &&
                        (alu_sum[WIDTH-1] != r_q[WIDTH-1]);
            end
            default: alu_f = '0;
        endcase
`ifdef ALB_SAT_EN
        // Chained ADC/SBC stay exact so multi-word arithmetic is not corrupted.
        if ((op_q == OP_ADD || op_q == OP_SUB) && alu_v) begin
            alu_f = r_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        r_d        = r_q;
        s_d        = s_q;
        ci_d       = ci_q;
        op_d       = op_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            r_d        = bus.r_in;
            s_d        = bus.s_in;
            ci_d       = bus.ci;
            op_d       = bus.op;
        end else if (move) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        f_d         = f_q;
        co_d        = co_q;
        vo_d        = vo_q;
        no_d        = no_q;
        zo_d        = zo_q;
        if (move) begin
            out_valid_d = 1'b1;
            f_d         = alu_f;
            co_d        = alu_c;
            vo_d        = alu_v;
            no_d        = alu_f[WIDTH-1];
            zo_d        = (alu_f == '0);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            r_q         <= '0;
            s_q         <= '0;
            ci_q        <= 1'b0;
            op_q        <= 3'b000;
            out_valid_q <= 1'b0;
            f_q         <= '0;
            co_q        <= 1'b0;
            vo_q        <= 1'b0;
            no_q        <= 1'b0;
            zo_q        <= 1'b1;
        end else begin
            s1_valid_q  <= s1_valid_d;
            r_q         <= r_d;
            s_q         <= s_d;
            ci_q        <= ci_d;
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
            f_q         <= f_d;
            co_q        <= co_d;
            vo_q        <= vo_d;
            no_q        <= no_d;
            zo_q        <= zo_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.f_out     = f_q;
    assign bus.co        = co_q;
    assign bus.vo        = vo_q;
    assign bus.no        = no_q;
    assign bus.zo        = zo_q;
endmodule
